// File: rtl/register_memory_pkg.sv
// Shared widths and index type for the integer register file.
package register_memory_pkg;

    localparam int WORD      = 64;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD-1:0]      word_t;

    // Each register resets to its own index, zero-extended.
    function automatic word_t reset_value(input reg_idx_t idx);
        return word_t'(idx);
    endfunction

endpackage

// File: rtl/register_memory.sv
// 32-entry register file: two combinational read ports, one synchronous write port.
// Reads are zero-latency; a write lands on the rising edge; no backpressure, and reset beats write.
module register_memory
    import register_memory_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_write,
    input  reg_idx_t        read_reg1,
    input  reg_idx_t        read_reg2,
    input  reg_idx_t        write_reg,
    input  logic [WORD-1:0] write_data,
    output logic [WORD-1:0] read_data1,
    output logic [WORD-1:0] read_data2
);

    word_t regs [NUM_REGS];

    // X31 is an ordinary register here; there is no hardwired zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reset_value(reg_idx_t'(i));
            end
        end else if (reg_write) begin
            regs[write_reg] <= write_data;
        end
    end

    // Same-index read during write shows the old value until the edge.
    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];

endmodule

// File: tb/tb_register_memory.sv
// Directed, table-driven bench for register_memory.
module tb_register_memory;
    import register_memory_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            reg_write;
    reg_idx_t        read_reg1;
    reg_idx_t        read_reg2;
    reg_idx_t        write_reg;
    logic [WORD-1:0] write_data;
    logic [WORD-1:0] read_data1;
    logic [WORD-1:0] read_data2;

    int checks   = 0;
    int failures = 0;

    register_memory dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            we;
        logic [4:0]      wr;
        logic [WORD-1:0] wd;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic [WORD-1:0] exp1;
        logic [WORD-1:0] exp2;
    } vec_t;

    vec_t vecs [$];

    localparam logic [WORD-1:0] ONES = {WORD{1'b1}};

    task automatic check(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; reads are checked before the next rising edge commits.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst        = v.rst;
        reg_write  = v.we;
        write_reg  = v.wr;
        write_data = v.wd;
        read_reg1  = v.r1;
        read_reg2  = v.r2;
        #1;
        check($sformatf("vec%0d.rd1", idx), read_data1, v.exp1);
        check($sformatf("vec%0d.rd2", idx), read_data2, v.exp2);
    endtask

    initial begin
        //           rst   we    wr     wd              r1     r2     exp1            exp2
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd31, 5'd5,  64'd31,         64'd5});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd20, 5'd17, 64'd20,         64'd17});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd0,  5'd7,  64'd0,          64'd7});
        vecs.push_back('{1'b0, 1'b1, 5'd11, 64'd100,        5'd11, 5'd11, 64'd11,         64'd11});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd11, 5'd10, 64'd100,        64'd10});
        vecs.push_back('{1'b0, 1'b1, 5'd1,  64'd123456789,  5'd1,  5'd2,  64'd1,          64'd2});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd2,  5'd1,  64'd2,          64'd123456789});
        vecs.push_back('{1'b1, 1'b1, 5'd4,  64'hDEAD,       5'd4,  5'd11, 64'd4,          64'd100});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd4,  5'd11, 64'd4,          64'd11});
        vecs.push_back('{1'b0, 1'b1, 5'd4,  64'hDEAD,       5'd4,  5'd1,  64'd4,          64'd1});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd4,  5'd4,  64'hDEAD,       64'hDEAD});
        vecs.push_back('{1'b1, 1'b0, 5'd0,  64'd0,          5'd4,  5'd4,  64'hDEAD,       64'hDEAD});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd4,  5'd4,  64'd4,          64'd4});
        vecs.push_back('{1'b0, 1'b1, 5'd31, ONES,           5'd31, 5'd30, 64'd31,         64'd30});
        vecs.push_back('{1'b0, 1'b0, 5'd31, 64'h1234,       5'd31, 5'd31, ONES,           ONES});
        vecs.push_back('{1'b0, 1'b0, 5'd3,  64'h5555,       5'd31, 5'd0,  ONES,           64'd0});
        vecs.push_back('{1'b0, 1'b0, 5'd0,  64'd0,          5'd30, 5'd3,  64'd30,         64'd3});

        rst        = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Read index change takes effect without any clock edge.
        @(negedge clk);
        reg_write = 1'b0;
        read_reg1 = 5'd3;
        #1 check("comb_idx_a", read_data1, 64'd3);
        read_reg1 = 5'd9;
        #1 check("comb_idx_b", read_data1, 64'd9);

        // Read-during-write on the same index: old value before the edge, new after.
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd6;
        write_data = 64'h0000_0ABC_0000_0ABC;
        read_reg1  = 5'd6;
        read_reg2  = 5'd6;
        #1 check("rdw_before", read_data1, 64'd6);
        @(posedge clk);
        #1;
        check("rdw_after1", read_data1, 64'h0000_0ABC_0000_0ABC);
        check("rdw_after2", read_data2, 64'h0000_0ABC_0000_0ABC);
        @(negedge clk);
        reg_write = 1'b0;

        // Mid-operation reset restores every register to its index.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            read_reg1 = reg_idx_t'(i);
            read_reg2 = reg_idx_t'(NUM_REGS - 1 - i);
            #1;
            check($sformatf("reset_all_rd1[%0d]", i), read_data1, 64'(i));
            check($sformatf("reset_all_rd2[%0d]", NUM_REGS - 1 - i), read_data2, 64'(NUM_REGS - 1 - i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
